// File: rtl/keypad_time_loader_pkg.sv
// ============================================================================
// Module   : keypad_time_loader_pkg
// Purpose  : Shared types and constants for the keypad time loader. It holds
//            the key codes, the BCD digit type, the loader FSM states and
//            the loader-wide widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_time_loader_pkg;

  localparam int DIGIT_W  = 4;  // one BCD digit
  localparam int COUNT_W  = 3;  // digit_count range 0..4
  localparam int LD_CNT_W = 2;  // load-cycle counter, holds LOAD_CYCLES-1 (0..3)

  localparam logic [COUNT_W-1:0] MAX_DIGITS = 3'd4;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    CHECK = 2'd2,
    LOAD  = 2'd3
  } loader_state_e;

  // Codes 0..9 are digits; everything above is a command or ignored.
  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_time_loader_key_edge_detect.sv
// ============================================================================
// Module   : key_edge_detect
// Purpose  : Takes an asynchronous key level through a 2-flop synchronizer
//            and an optional stability filter. It emits a single-cycle
//            accept pulse on the rising edge of the resulting level. The
//            block is reusable for the start/stop buttons.
// Macro    : LOADER_DEBOUNCE_EN - enables the DEBOUNCE_CYCLES stability
//            filter between the synchronizer and the edge detector.
// Ports    : clk     in  system clock
//            clearn  in  asynchronous active-low reset
//            key_in  in  raw key level (asynchronous)
//            accept  out one-cycle pulse, driven from flops only
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_edge_detect
`ifdef LOADER_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
  input  logic clk,
  input  logic clearn,
  input  logic key_in,
  output logic accept
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic level_prev_q, level_prev_d;
  logic level;

`ifdef LOADER_DEBOUNCE_EN
  localparam int STAB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              filt_q, filt_d;

  // Count consecutive samples that disagree with the filtered level. Any
  // agreeing sample restarts the count, so short glitches never flip it.
  always_comb begin
    stab_cnt_d = '0;
    filt_d     = filt_q;
    if (sync2_q != filt_q) begin
      if (stab_cnt_q == STAB_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        stab_cnt_d = stab_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      stab_cnt_q <= '0;
      filt_q     <= 1'b0;
    end else begin
      stab_cnt_q <= stab_cnt_d;
      filt_q     <= filt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    sync1_d      = key_in;
    sync2_d      = sync1_q;
    level_prev_d = level;
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_prev_q <= level_prev_d;
    end
  end

  assign accept = level & ~level_prev_q;

endmodule

`default_nettype wire

// File: rtl/keypad_time_loader.sv
// ============================================================================
// Module   : keypad_time_loader
// Purpose  : Collects keypad digits into a 4-digit mm:ss buffer and checks
//            the entry on ENTER. It then pulses the shared active-low load
//            strobe of the BCD down-counter chain for LOAD_CYCLES cycles.
// Macro    : LOADER_DEBOUNCE_EN - debounce key_valid for DEBOUNCE_CYCLES.
// Ports    : clk, clearn                 clock, async active-low reset
//            key_valid, key_code[3:0]    keypad level and code
//            counting_busy               timer running, keys ignored
//            data_min_tens..sec_ones     BCD buffer driven to the counters
//            loadn                       active-low load strobe
//            entry_active, digit_count   entry status
//            err                         one-cycle pulse on rejected enter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_time_loader
  import keypad_time_loader_pkg::*;
#(
  parameter int LOAD_CYCLES  = 1,
  parameter int MAX_SEC_TENS = 5
`ifdef LOADER_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       counting_busy,
  output logic [3:0] data_min_tens,
  output logic [3:0] data_min_ones,
  output logic [3:0] data_sec_tens,
  output logic [3:0] data_sec_ones,
  output logic       loadn,
  output logic       entry_active,
  output logic [2:0] digit_count,
  output logic       err
);

  loader_state_e      state_q, state_d;
  bcd_t [3:0]         digits_q, digits_d;  // [3]=min_tens ... [0]=sec_ones
  logic [COUNT_W-1:0] count_q, count_d;
  logic [LD_CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic               loadn_q, loadn_d;
  logic               err_q, err_d;
  logic               entry_q, entry_d;
  logic               key_accept;

  key_edge_detect
`ifdef LOADER_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
  u_key_edge (
    .clk    (clk),
    .clearn (clearn),
    .key_in (key_valid),
    .accept (key_accept)
  );

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    ld_cnt_d = ld_cnt_q;
    loadn_d  = 1'b1;
    err_d    = 1'b0;

    case (state_q)
      IDLE, ENTRY: begin
        if (key_accept && !counting_busy) begin
          if (is_digit(key_code)) begin
            // Shift left: min_tens falls off, the new digit enters sec_ones.
            digits_d = {digits_q[2:0], key_code};
            if (count_q != MAX_DIGITS) begin
              count_d = count_q + 3'd1;
            end
            state_d = ENTRY;
          end else if (key_code == KEY_CLEAR) begin
            digits_d = '0;
            count_d  = '0;
            state_d  = IDLE;
          end else if ((key_code == KEY_ENTER) && (count_q != '0)) begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (digits_q[1] > bcd_t'(MAX_SEC_TENS)) begin
          err_d    = 1'b1;
          digits_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end else begin
          // The first strobe cycle starts here; the counter holds how many
          // further low cycles remain.
          loadn_d  = 1'b0;
          ld_cnt_d = LD_CNT_W'(LOAD_CYCLES - 1);
          state_d  = LOAD;
        end
      end

      LOAD: begin
        if (ld_cnt_q == '0) begin
          digits_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end else begin
          loadn_d  = 1'b0;
          ld_cnt_d = ld_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    entry_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q  <= IDLE;
      digits_q <= '0;
      count_q  <= '0;
      ld_cnt_q <= '0;
      loadn_q  <= 1'b1;
      err_q    <= 1'b0;
      entry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      ld_cnt_q <= ld_cnt_d;
      loadn_q  <= loadn_d;
      err_q    <= err_d;
      entry_q  <= entry_d;
    end
  end

  assign data_min_tens = digits_q[3];
  assign data_min_ones = digits_q[2];
  assign data_sec_tens = digits_q[1];
  assign data_sec_ones = digits_q[0];
  assign loadn         = loadn_q;
  assign err           = err_q;
  assign entry_active  = entry_q;
  assign digit_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_time_loader.sv
// ============================================================================
// Module   : tb_keypad_time_loader
// Purpose  : Self-checking bench for keypad_time_loader. Two instances run
//            side by side, one with LOAD_CYCLES=1 and one with LOAD_CYCLES=3.
//            A timestamp-based model of the key/enter/load rules is compared
//            with both instances every cycle. Directed literal checks pin
//            the model to the expected values.
// Macro    : LOADER_DEBOUNCE_EN - switches the model and glitch test to the
//            debounced key path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_time_loader;

  localparam int L0    = 1;
  localparam int L1    = 3;
  localparam int MAXST = 5;
`ifdef LOADER_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  // Raw key_valid rise to the first loadn-low sample: one synchronizer cycle,
  // then edge detect, act and CHECK, plus the filter delay when debounced.
  localparam int LAT_LD = 4 + DEB;
  localparam int GAP    = 14;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       counting_busy = 1'b0;

  logic [1:0][3:0] mt_o, mo_o, st_o, so_o;
  logic [1:0]      loadn_o, ent_o, err_o;
  logic [1:0][2:0] dc_o;

  keypad_time_loader #(.LOAD_CYCLES(L0), .MAX_SEC_TENS(MAXST)) dut0 (
    .clk(clk), .clearn(clearn), .key_valid(key_valid), .key_code(key_code),
    .counting_busy(counting_busy),
    .data_min_tens(mt_o[0]), .data_min_ones(mo_o[0]),
    .data_sec_tens(st_o[0]), .data_sec_ones(so_o[0]),
    .loadn(loadn_o[0]), .entry_active(ent_o[0]), .digit_count(dc_o[0]),
    .err(err_o[0])
  );

  keypad_time_loader #(.LOAD_CYCLES(L1), .MAX_SEC_TENS(MAXST)) dut1 (
    .clk(clk), .clearn(clearn), .key_valid(key_valid), .key_code(key_code),
    .counting_busy(counting_busy),
    .data_min_tens(mt_o[1]), .data_min_ones(mo_o[1]),
    .data_sec_tens(st_o[1]), .data_sec_ones(so_o[1]),
    .loadn(loadn_o[1]), .entry_active(ent_o[1]), .digit_count(dc_o[1]),
    .err(err_o[1])
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  int  cyc = 0;
  bit  hist[16];           // hist[k] = key_valid sampled k edges ago
  bit  filt_m, fprev_m;
  int  m_dig[2][4];        // [0]=min_tens .. [3]=sec_ones
  int  m_cnt[2];
  int  m_t[2];             // edge at which an ENTER was accepted, -1 if none
  bit  m_ok[2];
  bit  m_err[2];
  bit  m_loadn[2];

  task automatic model_clear(input int i);
    for (int k = 0; k < 4; k++) m_dig[i][k] = 0;
    m_cnt[i] = 0;
  endtask

  task automatic model_step(input int i, input bit acc);
    int lc;
    int t;
    int win_end;
    bit ign;
    lc = (i == 0) ? L0 : L1;
    t  = m_t[i];
    m_err[i] = 1'b0;
    win_end = (t < 0) ? -1 : (m_ok[i] ? t + lc + 1 : t + 1);
    ign = (t >= 0) && (cyc >= t + 1) && (cyc <= win_end);
    m_loadn[i] = !((t >= 0) && m_ok[i] && (cyc >= t + 1) && (cyc <= t + lc));
    if ((t >= 0) && (cyc == win_end)) begin
      if (!m_ok[i]) m_err[i] = 1'b1;
      model_clear(i);
      m_t[i] = -1;
    end
    if (acc && !counting_busy && !ign) begin
      if (key_code <= 4'd9) begin
        m_dig[i][0] = m_dig[i][1];
        m_dig[i][1] = m_dig[i][2];
        m_dig[i][2] = m_dig[i][3];
        m_dig[i][3] = int'(key_code);
        if (m_cnt[i] < 4) m_cnt[i]++;
      end else if (key_code == 4'd10) begin
        model_clear(i);
      end else if ((key_code == 4'd11) && (m_cnt[i] > 0)) begin
        m_t[i]  = cyc;
        m_ok[i] = (m_dig[i][2] <= MAXST);
      end
    end
  endtask

  always @(posedge clk or negedge clearn) begin
    bit acc;
    bit all_diff;
    if (!clearn) begin
      for (int k = 0; k < 16; k++) hist[k] = 1'b0;
      filt_m  = 1'b0;
      fprev_m = 1'b0;
      for (int i = 0; i < 2; i++) begin
        model_clear(i);
        m_t[i]     = -1;
        m_ok[i]    = 1'b0;
        m_err[i]   = 1'b0;
        m_loadn[i] = 1'b1;
      end
    end else begin
      cyc++;
      for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = key_valid;
      if (DEB == 0) begin
        acc = hist[2] && !hist[3];
      end else begin
        // The filtered level flips once DEB consecutive synchronized samples
        // all disagree with it; a key is accepted on its rising edge.
        acc      = filt_m && !fprev_m;
        fprev_m  = filt_m;
        all_diff = 1'b1;
        for (int k = 2; k < 2 + DEB; k++) if (hist[k] == filt_m) all_diff = 1'b0;
        if (all_diff) filt_m = ~filt_m;
      end
      for (int i = 0; i < 2; i++) model_step(i, acc);
    end
  end

  // ---------------------------------------------------------------- checks
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int press_cyc = 0;
  int low_cnt[2];
  int err_cnt[2];
  int last_fall[2];
  bit prev_loadn[2];

  function automatic logic [15:0] dat(input int i);
    return {mt_o[i], mo_o[i], st_o[i], so_o[i]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input int hold);
    tick(1);
    key_code  = code;
    key_valid = 1'b1;
    press_cyc = ncyc;
    tick(hold);
    key_valid = 1'b0;
    tick(GAP);
  endtask

  initial begin
    int b_low0, b_low1, b_err0;
    for (int i = 0; i < 2; i++) begin
      low_cnt[i] = 0; err_cnt[i] = 0; last_fall[i] = -1; prev_loadn[i] = 1'b1;
    end
    fork
      forever begin : compare_and_monitor
        logic [21:0] exp_v, act_v;
        @(negedge clk);
        ncyc++;
        for (int i = 0; i < 2; i++) begin
          if (!loadn_o[i]) low_cnt[i]++;
          if (prev_loadn[i] && !loadn_o[i]) last_fall[i] = ncyc;
          prev_loadn[i] = loadn_o[i];
          if (err_o[i]) err_cnt[i]++;
          exp_v = {4'(m_dig[i][0]), 4'(m_dig[i][1]), 4'(m_dig[i][2]), 4'(m_dig[i][3]),
                   m_loadn[i], m_err[i], (m_cnt[i] != 0), 3'(m_cnt[i])};
          act_v = {dat(i), loadn_o[i], err_o[i], ent_o[i], dc_o[i]};
          checks++;
          if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_cmp inst%0d cyc=%0d actual=%h required=%h", i, ncyc, act_v, exp_v);
          end
        end
      end
      begin : stimulus
        // Reset values
        tick(3);
        check("rst_data", int'(dat(0)), 16'h0000);
        check("rst_loadn", int'(loadn_o[0]), 1);
        check("rst_count", int'(dc_o[0]), 0);
        check("rst_entry", int'(ent_o[0]), 0);
        check("rst_err", int'(err_o[0]), 0);
        clearn = 1'b1;
        tick(2);

        // 1,3,0 ENTER -> 0130, single strobe, buffer cleared
        press(4'd1, 6); press(4'd3, 6); press(4'd0, 6);
        check("e130_data", int'(dat(0)), 16'h0130);
        check("e130_count", int'(dc_o[0]), 3);
        check("e130_entry", int'(ent_o[0]), 1);
        b_low0 = low_cnt[0]; b_low1 = low_cnt[1];
        press(4'd11, 6);
        check("e130_latency", last_fall[0] - press_cyc, LAT_LD);
        check("e130_low_l1", low_cnt[0] - b_low0, 1);
        check("e130_low_l3", low_cnt[1] - b_low1, 3);
        check("e130_after", int'(dat(0)), 16'h0000);
        check("e130_cnt_after", int'(dc_o[1]), 0);

        // 1..5 -> 2345, count saturates at 4
        for (int k = 1; k <= 5; k++) press(4'(k), 6);
        check("sat_data", int'(dat(0)), 16'h2345);
        check("sat_count", int'(dc_o[0]), 4);
        press(4'd10, 6);
        check("clr_data", int'(dat(0)), 16'h0000);
        check("clr_entry", int'(ent_o[0]), 0);

        // ENTER with no digits is ignored
        b_low0 = low_cnt[0];
        press(4'd11, 6);
        check("enter_empty", low_cnt[0] - b_low0, 0);

        // 9,0 ENTER -> sec_tens 9 rejected
        press(4'd9, 6); press(4'd0, 6);
        check("e90_data", int'(dat(0)), 16'h0090);
        b_low0 = low_cnt[0]; b_err0 = err_cnt[0];
        press(4'd11, 6);
        check("e90_err", err_cnt[0] - b_err0, 1);
        check("e90_noload", low_cnt[0] - b_low0, 0);
        check("e90_after", int'(dat(0)), 16'h0000);

        // Held key counts once; busy blocks keys; codes 12-15 ignored
        press(4'd7, 20);
        check("hold_count", int'(dc_o[0]), 1);
        check("hold_data", int'(dat(0)), 16'h0007);
        counting_busy = 1'b1;
        press(4'd7, 6);
        counting_busy = 1'b0;
        check("busy_data", int'(dat(0)), 16'h0007);
        press(4'd13, 6);
        check("code13_count", int'(dc_o[0]), 1);
        press(4'd10, 6);

        // Glitch on key_valid, then a full press
        tick(1);
        key_code = 4'd8; key_valid = 1'b1;
        tick(2);
        key_valid = 1'b0;
        tick(GAP);
        check("glitch_count", int'(dc_o[0]), (DEB == 0) ? 1 : 0);
        press(4'd8, 6);
        check("press_count", int'(dc_o[0]), (DEB == 0) ? 2 : 1);
        check("press_data", int'(dat(0)), (DEB == 0) ? 16'h0088 : 16'h0008);
        press(4'd10, 6);

        // Reset during the 2nd low cycle of a 3-cycle load
        press(4'd4, 6); press(4'd5, 6);
        b_low1 = low_cnt[1];
        tick(1);
        key_code = 4'd11; key_valid = 1'b1;
        for (int k = 0; k < 60 && (low_cnt[1] - b_low1) < 2; k++) tick(1);
        check("rst_mid_reached", low_cnt[1] - b_low1, 2);
        key_valid = 1'b0;
        #2;
        clearn = 1'b0;
        #1;
        check("rstmid_loadn", int'(loadn_o[1]), 1);
        check("rstmid_data", int'(dat(1)), 16'h0000);
        check("rstmid_count", int'(dc_o[1]), 0);
        check("rstmid_entry", int'(ent_o[1]), 0);
        check("rstmid_err", int'(err_o[1]), 0);
        tick(2);
        clearn = 1'b1;
        tick(4);
        check("post_rst_loadn", int'(loadn_o[1]), 1);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/keypad_time_loader.md
Name: keypad_time_loader

Overview:
- Producer side of the BCD down-counter load interface: collects keypad digits into a 4-digit mm:ss buffer and drives each digit counter's data/loadn pins.
- Sits between the keypad encoder and the timer's chain of mod-10/mod-6 counters.
- Validates the entry, then issues an active-low load strobe so the counters capture the entered time.

Parameters:
- LOAD_CYCLES, 1, number of cycles loadn is held low per load (1..4).
- DEBOUNCE_CYCLES, 4, cycles key_valid must stay stable before acceptance (only with debounce feature).
- MAX_SEC_TENS, 5, largest legal seconds-tens digit.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clearn  in  1  asynchronous active-low reset.
- key_valid  in  1  level, high while a key is held.
- key_code  in  4  0-9 digit, 10 clear, 11 enter, 12-15 ignored.
- counting_busy  in  1  timer running; all keys are ignored while high.
- data_min_tens, data_min_ones, data_sec_tens, data_sec_ones  out  4 each  BCD data to the counters, driven from the buffer.
- loadn  out  1  active-low load strobe shared by all four counters.
- entry_active  out  1  high while the buffer holds at least one digit.
- digit_count  out  3  number of digits entered, 0..4.
- err  out  1  one-cycle pulse on a rejected enter.

Behaviour:
- Reset: buffer = 0000, digit_count = 0, loadn = 1, err = 0, entry_active = 0, FSM = IDLE. Reset mid-load aborts the load and releases loadn immediately.
- Key acceptance: a key is accepted once, on the rising edge of key_valid; holding the key does not repeat it.
  - The key is acted on the cycle after the edge.
  - Edges are ignored while counting_busy = 1 or the FSM is in LOAD.
- IDLE / ENTRY states:
  - Digit key: buffer shifts left one digit (min_tens is lost) and the new digit enters sec_ones. digit_count increments and saturates at 4; a 5th digit still shifts.
  - Going from IDLE to ENTRY on the first digit sets entry_active = 1.
  - Clear key: buffer = 0, digit_count = 0, FSM to IDLE.
  - Enter key with digit_count = 0: ignored.
  - Enter key with digit_count > 0: FSM to CHECK.
  - Codes 12-15: ignored.
- CHECK state (1 cycle):
  - sec_tens > MAX_SEC_TENS: err = 1 for one cycle, buffer cleared, FSM to IDLE.
  - Otherwise: FSM to LOAD.
- LOAD state:
  - loadn = 0 for exactly LOAD_CYCLES cycles. data_* stays stable throughout and equals the buffer.
  - After those cycles, loadn = 1, the buffer clears on the next cycle, digit_count = 0, FSM to IDLE.
- data_* always mirrors the buffer, so the display shows the entry while typing.
- Output timing: loadn, err and entry_active are registered outputs with no combinational path from the inputs.
- Latency: enter edge to first loadn low = 3 cycles (edge detect, act, CHECK).

Optional Feature:
- Macro: LOADER_DEBOUNCE_EN.
- Defined: key_valid is sampled through a stability counter. The filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples, and edge detection runs on the filtered level. Glitches shorter than DEBOUNCE_CYCLES are dropped.
- Undefined: a plain 2-flop synchronizer plus edge detect, with no filtering.

Decomposition:
- Shared package holds:
  - key code constants: KEY_CLEAR = 10, KEY_ENTER = 11.
  - 4-bit BCD digit typedef.
  - FSM state enum: IDLE, ENTRY, CHECK, LOAD.
  - loader-wide width constants.
- One sub-module, key_edge_detect: synchronizer, optional debounce and single-cycle accept pulse. It is reusable for the start/stop buttons.

Test Plan:
- Keys 1,3,0 then enter -> data = 0,1,3,0; loadn low 1 cycle, 3 cycles after the enter edge; buffer 0000 afterwards.
- Keys 1,2,3,4,5 -> data = 2,3,4,5, digit_count = 4.
- Keys 9,0 then enter -> sec_tens = 9, err pulse, no loadn, buffer 0000.
- Key 7 held 20 cycles -> a single digit accepted. Key 7 with counting_busy = 1 -> buffer unchanged.
- LOAD_CYCLES = 3, keys 4,5 enter, clearn asserted on 2nd loadn-low cycle -> loadn = 1 immediately, all outputs at reset values.
- With LOADER_DEBOUNCE_EN and DEBOUNCE_CYCLES = 4 -> a 2-cycle key_valid glitch is ignored; a 6-cycle press is accepted once.
